// File: rtl/sseg_scan_pkg.sv
// Shared types and constants for the sseg_scan seven-segment scanner.
// Optional dimming is enabled by defining SSEG_SCAN_DIM_EN.
package sseg_scan_pkg;

   localparam int NUM_DIGITS = 4;

   typedef enum logic {
      BLANK = 1'b0,
      SHOW  = 1'b1
   } phase_t;

   typedef logic [1:0] digit_t;

   localparam logic [7:0] SEG_DARK = 8'h00;

   function automatic logic [3:0] digit_onehot(input digit_t d);
      return 4'b0001 << d;
   endfunction

endpackage

// File: rtl/sseg_scan_if.sv
// Pattern inputs and display outputs of sseg_scan, grouped as one bundle.
// The dim field exists only when SSEG_SCAN_DIM_EN is defined.
interface sseg_scan_if;
   import sseg_scan_pkg::*;

   logic [7:0] sseg0_in;
   logic [7:0] sseg1_in;
   logic [7:0] sseg2_in;
   logic [7:0] sseg3_in;
   logic [7:0] seg_out;
   logic [3:0] an_out;
   logic       frame_start;
`ifdef SSEG_SCAN_DIM_EN
   logic [2:0] dim;
`endif

   modport master (
      input  seg_out, an_out, frame_start,
      output sseg0_in, sseg1_in, sseg2_in, sseg3_in
`ifdef SSEG_SCAN_DIM_EN
      , dim
`endif
   );

   modport slave (
      output seg_out, an_out, frame_start,
      input  sseg0_in, sseg1_in, sseg2_in, sseg3_in
`ifdef SSEG_SCAN_DIM_EN
      , dim
`endif
   );

endinterface

// File: rtl/sseg_scan_timer.sv
// Slot counter, digit index and BLANK/SHOW phase FSM for sseg_scan.
// With SSEG_SCAN_DIM_EN it also exposes the position within SHOW.
module sseg_scan_timer
   import sseg_scan_pkg::*;
#(
   parameter int DIGIT_CYCLES = 50000,
   parameter int BLANK_CYCLES = 500
) (
   input  logic        clk_i,
   input  logic        rst_ni,
`ifdef SSEG_SCAN_DIM_EN
   output logic [2:0]  show_cnt_o,
`endif
   output digit_t      digit_o,
   output logic        show_o,
   output logic        load_o
);

   localparam int CW = (DIGIT_CYCLES > 1) ? $clog2(DIGIT_CYCLES) : 1;
   localparam logic [CW-1:0] LAST = CW'(DIGIT_CYCLES - 1);

   logic [CW-1:0] cnt_q, cnt_d;
   digit_t        digit_q, digit_d;
   phase_t        state_q, state_d;
   logic          blank_next_s;

   // slot counter wrap and digit advance
   always_comb begin
      if (cnt_q == LAST) begin
         cnt_d   = {CW{1'b0}};
         digit_d = digit_q + 2'd1;
      end else begin
         cnt_d   = cnt_q + CW'(1);
         digit_d = digit_q;
      end
      blank_next_s = (int'(cnt_d) < BLANK_CYCLES);
   end

   // phase FSM next state tracks the next counter value
   always_comb begin
      state_d = state_q;
      case (state_q)
         BLANK: begin
            if (!blank_next_s) state_d = SHOW;
            else               state_d = BLANK;
         end
         SHOW: begin
            if (blank_next_s)  state_d = BLANK;
            else               state_d = SHOW;
         end
         default: state_d = BLANK;
      endcase
   end

   // timer state registers
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q   <= {CW{1'b0}};
         digit_q <= 2'd0;
         state_q <= BLANK;
      end else begin
         cnt_q   <= cnt_d;
         digit_q <= digit_d;
         state_q <= state_d;
      end
   end

   // Reset state is BLANK; with no blanking the first slot cycle is already lit.
   assign show_o  = (state_q == SHOW) || (BLANK_CYCLES == 0);
   assign load_o  = (cnt_q == {CW{1'b0}}) && (digit_q == 2'd0);
   assign digit_o = digit_q;
`ifdef SSEG_SCAN_DIM_EN
   assign show_cnt_o = 3'(cnt_q - CW'(BLANK_CYCLES));
`endif

endmodule

// File: rtl/sseg_scan.sv
// Four-digit multiplexed seven-segment scanner with per-frame pattern snapshot.
// Define SSEG_SCAN_DIM_EN to add 3-bit PWM dimming within each SHOW phase.
module sseg_scan
   import sseg_scan_pkg::*;
#(
   parameter int DIGIT_CYCLES   = 50000,
   parameter int BLANK_CYCLES   = 500,
   parameter int SEG_ACTIVE_LOW = 1,
   parameter int AN_ACTIVE_LOW  = 1
) (
   input logic        clk_clk,
   input logic        reset_reset_n,
   sseg_scan_if.slave bus
);

   localparam logic [7:0] SEG_OFF = (SEG_ACTIVE_LOW != 0) ? 8'hFF : 8'h00;
   localparam logic [3:0] AN_OFF  = (AN_ACTIVE_LOW  != 0) ? 4'hF  : 4'h0;

   digit_t     digit_s;
   logic       show_s, load_s, lit_s;
   logic [7:0] in_s [NUM_DIGITS];
   logic [7:0] shadow_q [NUM_DIGITS];
   logic [7:0] pat_s, seg_d, seg_q;
   logic [3:0] an_d, an_q;
   logic       fs_q;
`ifdef SSEG_SCAN_DIM_EN
   logic [2:0] show_cnt_s, dim_q, dim_sel_s;
`endif

   sseg_scan_timer #(
      .DIGIT_CYCLES(DIGIT_CYCLES),
      .BLANK_CYCLES(BLANK_CYCLES)
   ) u_timer (
      .clk_i      (clk_clk),
      .rst_ni     (reset_reset_n),
`ifdef SSEG_SCAN_DIM_EN
      .show_cnt_o (show_cnt_s),
`endif
      .digit_o    (digit_s),
      .show_o     (show_s),
      .load_o     (load_s)
   );

   assign in_s[0] = bus.sseg0_in;
   assign in_s[1] = bus.sseg1_in;
   assign in_s[2] = bus.sseg2_in;
   assign in_s[3] = bus.sseg3_in;

   // frame snapshot of the input patterns
   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         for (int i = 0; i < NUM_DIGITS; i++) shadow_q[i] <= SEG_DARK;
`ifdef SSEG_SCAN_DIM_EN
         dim_q <= 3'd0;
`endif
      end else if (load_s) begin
         for (int i = 0; i < NUM_DIGITS; i++) shadow_q[i] <= in_s[i];
`ifdef SSEG_SCAN_DIM_EN
         dim_q <= bus.dim;
`endif
      end
   end

   // Bypass the snapshot on the load cycle so a zero-blank slot shows the new frame at once.
   always_comb begin
      pat_s = load_s ? in_s[digit_s] : shadow_q[digit_s];
      lit_s = show_s;
`ifdef SSEG_SCAN_DIM_EN
      dim_sel_s = load_s ? bus.dim : dim_q;
      lit_s     = show_s && (show_cnt_s <= dim_sel_s);
`endif
      if (lit_s) begin
         an_d  = digit_onehot(digit_s);
         seg_d = pat_s;
      end else begin
         an_d  = 4'h0;
         seg_d = SEG_DARK;
      end
   end

   // registered pin outputs with polarity applied
   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         an_q  <= AN_OFF;
         seg_q <= SEG_OFF;
         fs_q  <= 1'b0;
      end else begin
         an_q  <= an_d ^ AN_OFF;
         seg_q <= seg_d ^ SEG_OFF;
         fs_q  <= load_s;
      end
   end

   assign bus.an_out      = an_q;
   assign bus.seg_out     = seg_q;
   assign bus.frame_start = fs_q;

endmodule
